// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 encodings, FSM states
// and the legality check for a memory op's funct3.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } lsu_state_e;

    // Unsigned variants only exist for loads.
    function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return is_load;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte-enables/replication, load byte/half
// extraction with sign or zero extension, and the misalignment flag.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  wmask,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        wmask      = 4'b0000;
        wdata      = '0;
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                wmask = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                wmask      = 4'b0011 << addr_lo;
                wdata      = {2{store_data[15:0]}};
                misaligned = addr_lo[0];
            end
            default: begin
                wmask      = 4'b1111;
                wdata      = store_data;
                misaligned = (addr_lo != 2'b00);
            end
        endcase
    end

    always_comb begin
        byte_val = rdata[7:0];
        case (addr_lo)
            2'd0:    byte_val = rdata[7:0];
            2'd1:    byte_val = rdata[15:8];
            2'd2:    byte_val = rdata[23:16];
            default: byte_val = rdata[31:24];
        endcase
        half_val = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        load_data = rdata;
        case (funct3)
            F3_B:    load_data = {{24{byte_val[7]}}, byte_val};
            F3_BU:   load_data = {24'b0, byte_val};
            F3_H:    load_data = {{16{half_val[15]}}, half_val};
            F3_HU:   load_data = {16'b0, half_val};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory-access stage: one outstanding access on a req/gnt/rvalid data bus,
// with a single-cycle writeback pulse per op (including rejected ops).
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DataWidth = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ex_valid,
    output logic                 ex_ready,
    input  logic                 ex_load,
    input  logic                 ex_store,
    input  logic [2:0]           ex_funct3,
    input  logic [DataWidth-1:0] ex_addr,
    input  logic [DataWidth-1:0] ex_store_data,
    input  logic [4:0]           ex_rd,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [DataWidth-1:0] mem_addr,
    output logic [DataWidth-1:0] mem_wdata,
    output logic [3:0]           mem_wmask,
    input  logic                 mem_gnt,
    input  logic                 mem_rvalid,
    input  logic [DataWidth-1:0] mem_rdata,
    output logic                 wb_valid,
    output logic                 wb_we,
    output logic [4:0]           wb_rd,
    output logic [DataWidth-1:0] wb_data,
    output logic                 wb_err,
    output logic                 stall,
    output lsu_state_e           fsm_state
);

    lsu_state_e state;
    logic       op_load;
    logic [1:0] op_addr_lo;
    logic [2:0] op_f3;

    logic [1:0]           align_addr;
    logic [2:0]           align_f3;
    logic [3:0]           align_wmask;
    logic [DataWidth-1:0] align_wdata;
    logic [DataWidth-1:0] align_load;
    logic                 align_misaligned;
    logic                 bad_op;

    // Handshakes: an op transfers on ex_valid & ex_ready; the bus request
    // transfers on mem_req & mem_gnt; mem_rvalid is a one-cycle data strobe.
    assign ex_ready  = (state == S_IDLE);
    assign stall     = ex_valid & ~ex_ready;
    assign fsm_state = state;

    // The aligner sees the live op while idle (store lanes, misalignment) and
    // the latched op afterwards (load extraction).
    assign align_addr = ex_ready ? ex_addr[1:0] : op_addr_lo;
    assign align_f3   = ex_ready ? ex_funct3 : op_f3;
    assign bad_op     = (ex_load == ex_store) || !f3_legal(ex_load, ex_funct3);

    lsu_align u_align (
        .addr_lo    (align_addr),
        .funct3     (align_f3),
        .store_data (ex_store_data),
        .rdata      (mem_rdata),
        .wmask      (align_wmask),
        .wdata      (align_wdata),
        .load_data  (align_load),
        .misaligned (align_misaligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            op_load    <= 1'b0;
            op_addr_lo <= 2'b00;
            op_f3      <= 3'b000;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wmask  <= 4'b0000;
            wb_valid   <= 1'b0;
            wb_we      <= 1'b0;
            wb_rd      <= 5'd0;
            wb_data    <= '0;
            wb_err     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ex_valid) begin
                        op_load    <= ex_load;
                        op_addr_lo <= ex_addr[1:0];
                        op_f3      <= ex_funct3;
                        wb_rd      <= ex_rd;
                        if (bad_op || align_misaligned) begin
                            state    <= S_RESP;
                            wb_valid <= 1'b1;
                            wb_err   <= 1'b1;
                            wb_we    <= 1'b0;
                            wb_data  <= '0;
                        end else begin
                            state     <= S_REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= ex_store;
                            mem_addr  <= {ex_addr[DataWidth-1:2], 2'b00};
                            mem_wdata <= ex_store ? align_wdata : '0;
                            mem_wmask <= ex_store ? align_wmask : 4'b0000;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (op_load) begin
                            state <= S_WAIT;
                        end else begin
                            state    <= S_RESP;
                            wb_valid <= 1'b1;
                            wb_we    <= 1'b0;
                            wb_err   <= 1'b0;
                            wb_data  <= '0;
                        end
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        state    <= S_RESP;
                        wb_valid <= 1'b1;
                        wb_we    <= 1'b1;
                        wb_err   <= 1'b0;
                        wb_data  <= align_load;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    wb_valid <= 1'b0;
                    wb_we    <= 1'b0;
                    wb_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, loads, rejected ops, bus stalls
// and asynchronous reset in the middle of a transaction.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_load;
    logic        ex_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_err;
    logic        stall;
    lsu_state_e  fsm_state;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];

    int          r_lat;
    int          r_req_cnt;
    int          r_wb_cnt;
    logic        r_unstable;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wmask;
    logic        r_we;
    logic        r_wb_we;
    logic        r_wb_err;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;

    load_store_unit #(.DataWidth(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_load       (ex_load),
        .ex_store      (ex_store),
        .ex_funct3     (ex_funct3),
        .ex_addr       (ex_addr),
        .ex_store_data (ex_store_data),
        .ex_rd         (ex_rd),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_gnt       (mem_gnt),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .wb_valid      (wb_valid),
        .wb_we         (wb_we),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .wb_err        (wb_err),
        .stall         (stall),
        .fsm_state     (fsm_state)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic set_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] rd);
        ex_load       = ld;
        ex_store      = st;
        ex_funct3     = f3;
        ex_addr       = addr;
        ex_store_data = sdata;
        ex_rd         = rd;
        ex_valid      = 1'b1;
    endtask

    // Driver: issues one op and plays the bus with the given grant/rvalid delays.
    // Latency is counted in cycles after the acceptance cycle; -1 means no wb_valid.
    task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] rd,
                          input int gnt_dly, input int rv_dly, input logic [31:0] rdata);
        int gcyc;
        r_lat = -1; r_req_cnt = 0; r_wb_cnt = 0; r_unstable = 1'b0; gcyc = -1;
        r_addr = '0; r_wdata = '0; r_wmask = '0; r_we = 1'b0;
        r_wb_we = 1'b0; r_wb_err = 1'b0; r_wb_rd = '0; r_wb_data = '0;
        set_op(ld, st, f3, addr, sdata, rd);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
            if (wb_valid) begin
                r_wb_cnt++;
                if (r_lat < 0) begin
                    r_lat = cyc; r_wb_we = wb_we; r_wb_err = wb_err; r_wb_rd = wb_rd; r_wb_data = wb_data;
                end
            end
            if (r_lat >= 0 && cyc >= r_lat + 2) break;
            if (mem_req) begin
                if (r_req_cnt == 0) begin
                    r_addr = mem_addr; r_wdata = mem_wdata; r_wmask = mem_wmask; r_we = mem_we;
                end else if (mem_addr !== r_addr || mem_wdata !== r_wdata || mem_wmask !== r_wmask || mem_we !== r_we) begin
                    r_unstable = 1'b1;
                end
                if (r_req_cnt == gnt_dly) begin
                    mem_gnt = 1'b1; gcyc = cyc;
                end
                r_req_cnt++;
            end
            if (ld && gcyc > 0 && cyc == gcyc + 1 + rv_dly) begin
                mem_rvalid = 1'b1; mem_rdata = rdata;
            end
            @(posedge clk); #1;
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_funct3 = '0;
        ex_addr = '0; ex_store_data = '0; ex_rd = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({mem_req, mem_we, mem_wmask, wb_valid, wb_we, wb_err} !== 9'b0) begin errors++; $display("FAIL reset_ctrl got %b exp 0", {mem_req, mem_we, mem_wmask, wb_valid, wb_we, wb_err}); end
        checks++; if ({mem_addr, mem_wdata, wb_data, wb_rd} !== 101'b0) begin errors++; $display("FAIL reset_data got addr %h wdata %h data %h rd %0d exp 0", mem_addr, mem_wdata, wb_data, wb_rd); end
        checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ex_ready); end
        checks++; if (fsm_state !== S_IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", fsm_state, S_IDLE); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_stores();
        logic [2:0]  f3 [6]  = '{F3_W, F3_B, F3_B, F3_H, F3_H, F3_W};
        logic [31:0] ad [6]  = '{32'h100, 32'h103, 32'h101, 32'h102, 32'h100, 32'h2C};
        logic [31:0] sd [6]  = '{32'hDEADBEEF, 32'h000000A5, 32'h123456C3, 32'h1234BEEF, 32'hAAAA1357, 32'h0BADF00D};
        logic [3:0]  em [6]  = '{4'b1111, 4'b1000, 4'b0010, 4'b1100, 4'b0011, 4'b1111};
        logic [31:0] ed [6]  = '{32'hDEADBEEF, 32'hA5A5A5A5, 32'hC3C3C3C3, 32'hBEEFBEEF, 32'h13571357, 32'h0BADF00D};
        int          gd [6]  = '{0, 0, 0, 0, 0, 2};
        int          el [6]  = '{2, 2, 2, 2, 2, 4};
        for (int i = 0; i < 6; i++) begin
            run_op(1'b0, 1'b1, f3[i], ad[i], sd[i], 5'd4, gd[i], 0, 32'h0);
            checks++; if (r_addr !== {ad[i][31:2], 2'b00}) begin errors++; $display("FAIL st%0d_addr got %h exp %h", i, r_addr, {ad[i][31:2], 2'b00}); end
            checks++; if (r_wmask !== em[i]) begin errors++; $display("FAIL st%0d_wmask got %b exp %b", i, r_wmask, em[i]); end
            checks++; if (r_wdata !== ed[i]) begin errors++; $display("FAIL st%0d_wdata got %h exp %h", i, r_wdata, ed[i]); end
            checks++; if (r_we !== 1'b1) begin errors++; $display("FAIL st%0d_we got %b exp 1", i, r_we); end
            checks++; if (r_lat !== el[i]) begin errors++; $display("FAIL st%0d_latency got %0d exp %0d", i, r_lat, el[i]); end
            checks++; if (r_req_cnt !== gd[i] + 1) begin errors++; $display("FAIL st%0d_req_cycles got %0d exp %0d", i, r_req_cnt, gd[i] + 1); end
            checks++; if ({r_wb_cnt, r_wb_we, r_wb_err, r_unstable} !== {32'd1, 3'b000}) begin errors++; $display("FAIL st%0d_wb got cnt %0d we %b err %b unstable %b exp 1 0 0 0", i, r_wb_cnt, r_wb_we, r_wb_err, r_unstable); end
        end
    endtask

    task automatic test_loads();
        logic [2:0]  f3 [6] = '{F3_B, F3_BU, F3_H, F3_HU, F3_W, F3_B};
        logic [31:0] ad [6] = '{32'h201, 32'h201, 32'h202, 32'h202, 32'h204, 32'h200};
        logic [31:0] rv [6] = '{32'h12348000, 32'h12348000, 32'h80011234, 32'h80011234, 32'hCAFEF00D, 32'hFFFFFF7F};
        logic [4:0]  rd [6] = '{5'd1, 5'd2, 5'd7, 5'd8, 5'd0, 5'd31};
        logic [31:0] ev [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001, 32'hCAFEF00D, 32'h0000007F};
        logic [31:0] exp_v;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(ev[i]);
            run_op(1'b1, 1'b0, f3[i], ad[i], 32'hFFFFFFFF, rd[i], 0, 0, rv[i]);
            exp_v = exp_q.pop_front();
            checks++; if (r_wb_data !== exp_v) begin errors++; $display("FAIL ld%0d_data got %h exp %h", i, r_wb_data, exp_v); end
            checks++; if (r_wb_rd !== rd[i]) begin errors++; $display("FAIL ld%0d_rd got %0d exp %0d", i, r_wb_rd, rd[i]); end
            checks++; if (r_lat !== 3) begin errors++; $display("FAIL ld%0d_latency got %0d exp 3", i, r_lat); end
            checks++; if (r_addr !== {ad[i][31:2], 2'b00}) begin errors++; $display("FAIL ld%0d_addr got %h exp %h", i, r_addr, {ad[i][31:2], 2'b00}); end
            checks++; if ({r_we, r_wmask} !== 5'b0) begin errors++; $display("FAIL ld%0d_bus got we %b wmask %b exp 0 0000", i, r_we, r_wmask); end
            checks++; if ({r_wb_cnt, r_wb_we, r_wb_err} !== {32'd1, 2'b10}) begin errors++; $display("FAIL ld%0d_wb got cnt %0d we %b err %b exp 1 1 0", i, r_wb_cnt, r_wb_we, r_wb_err); end
        end
    endtask

    task automatic test_errors();
        logic        ld [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic        st [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [2:0]  f3 [8] = '{F3_W, F3_H, F3_W, F3_H, F3_W, F3_W, F3_BU, 3'b011};
        logic [31:0] ad [8] = '{32'h102, 32'h101, 32'h101, 32'h003, 32'h100, 32'h100, 32'h100, 32'h100};
        for (int i = 0; i < 8; i++) begin
            run_op(ld[i], st[i], f3[i], ad[i], 32'h12345678, 5'(10 + i), 0, 0, 32'h55555555);
            checks++; if (r_lat !== 1) begin errors++; $display("FAIL err%0d_latency got %0d exp 1", i, r_lat); end
            checks++; if (r_req_cnt !== 0) begin errors++; $display("FAIL err%0d_req got %0d cycles exp 0", i, r_req_cnt); end
            checks++; if ({r_wb_err, r_wb_we, r_wb_data} !== {2'b10, 32'h0}) begin errors++; $display("FAIL err%0d_wb got err %b we %b data %h exp 1 0 0", i, r_wb_err, r_wb_we, r_wb_data); end
            checks++; if (r_wb_rd !== 5'(10 + i) || r_wb_cnt !== 1) begin errors++; $display("FAIL err%0d_rd got rd %0d cnt %0d exp %0d 1", i, r_wb_rd, r_wb_cnt, 10 + i); end
        end
    endtask

    task automatic test_back_to_back();
        int req_bad = 0;
        int stall_bad = 0;
        int wb_cnt = 0;
        int wb_cyc = -1;
        logic [31:0] got_data = '0;
        logic [4:0]  got_rd = '0;
        set_op(1'b1, 1'b0, F3_W, 32'h300, 32'h0, 5'd9);
        checks++; if (ex_ready !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL b2b_accept got ready %b stall %b exp 1 0", ex_ready, stall); end
        @(posedge clk); #1;
        set_op(1'b0, 1'b1, F3_W, 32'h310, 32'h55AA55AA, 5'd3);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
            if (stall !== 1'b1) stall_bad++;
            if (mem_req !== (cyc <= 4)) req_bad++;
            if (mem_req && (mem_addr !== 32'h300 || mem_we !== 1'b0 || mem_wmask !== 4'b0000)) req_bad++;
            if (wb_valid) begin wb_cnt++; wb_cyc = cyc; got_data = wb_data; got_rd = wb_rd; end
            if (cyc == 4) mem_gnt = 1'b1;
            if (cyc == 7) begin mem_rvalid = 1'b1; mem_rdata = 32'h11223344; end
            @(posedge clk); #1;
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        checks++; if (req_bad !== 0) begin errors++; $display("FAIL b2b_req_hold got %0d bad cycles exp 0", req_bad); end
        checks++; if (stall_bad !== 0) begin errors++; $display("FAIL b2b_stall got %0d low cycles exp 0", stall_bad); end
        checks++; if (wb_cnt !== 1 || wb_cyc !== 8) begin errors++; $display("FAIL b2b_wb_once got cnt %0d at cycle %0d exp 1 at 8", wb_cnt, wb_cyc); end
        checks++; if (got_data !== 32'h11223344 || got_rd !== 5'd9) begin errors++; $display("FAIL b2b_wb_data got %h rd %0d exp 11223344 rd 9", got_data, got_rd); end
        checks++; if (ex_ready !== 1'b1 || stall !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_ready_after got ready %b stall %b wb %b exp 1 0 0", ex_ready, stall, wb_valid); end
        @(posedge clk); #1;
        ex_valid = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h310 || mem_wmask !== 4'b1111 || mem_wdata !== 32'h55AA55AA) begin errors++; $display("FAIL b2b_second_req got req %b addr %h mask %b wdata %h exp 1 310 1111 55aa55aa", mem_req, mem_addr, mem_wmask, mem_wdata); end
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        checks++; if (wb_valid !== 1'b1 || wb_we !== 1'b0 || wb_err !== 1'b0 || wb_rd !== 5'd3) begin errors++; $display("FAIL b2b_second_wb got valid %b we %b err %b rd %0d exp 1 0 0 3", wb_valid, wb_we, wb_err, wb_rd); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int stray_wb = 0;
        set_op(1'b1, 1'b0, F3_W, 32'h400, 32'h0, 5'd5);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        checks++; if (fsm_state !== S_WAIT || mem_addr !== 32'h400) begin errors++; $display("FAIL rst_pre_wait got state %0d addr %h exp %0d 400", fsm_state, mem_addr, S_WAIT); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || wb_valid !== 1'b0 || mem_addr !== 32'h0 || ex_ready !== 1'b1) begin errors++; $display("FAIL rst_async_wait got req %b wb %b addr %h ready %b exp 0 0 0 1", mem_req, wb_valid, mem_addr, ex_ready); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        mem_rvalid = 1'b1; mem_rdata = 32'h99999999;
        @(posedge clk); #1;
        mem_rvalid = 1'b0; mem_rdata = '0;
        for (int i = 0; i < 4; i++) begin
            if (wb_valid) stray_wb++;
            @(posedge clk); #1;
        end
        checks++; if (stray_wb !== 0) begin errors++; $display("FAIL rst_stray_rvalid got %0d wb pulses exp 0", stray_wb); end
        set_op(1'b0, 1'b1, F3_W, 32'h500, 32'h1, 5'd1);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_pre_req got %b exp 1", mem_req); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_wmask !== 4'b0000) begin errors++; $display("FAIL rst_async_req got req %b we %b mask %b exp 0 0 0000", mem_req, mem_we, mem_wmask); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(1'b1, 1'b0, F3_BU, 32'h403, 32'h0, 5'd6, 0, 0, 32'hAB000000);
        checks++; if (r_lat !== 3 || r_wb_data !== 32'h000000AB || r_wb_we !== 1'b1 || r_wb_rd !== 5'd6) begin errors++; $display("FAIL rst_after_op got lat %0d data %h we %b rd %0d exp 3 000000ab 1 6", r_lat, r_wb_data, r_wb_we, r_wb_rd); end
    endtask

    initial begin
        test_reset();
        test_stores();
        test_loads();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
